dram_port_arbiter: RTL and testbench
====================================

Name: dram_port_arbiter

Overview:
- Shares the single-port, 1-cycle-read-latency data RAM (DRAM) between two requesters.
  - m0: CPU MEM-stage load/store.
  - m1: trace/debug/loader master.
- Arbitrates requests and converts byte addresses plus access size into a word address and byte-lane write strobes.
- Tracks outstanding reads so each RAM output word is aligned, extended and returned to the correct requester.
- Sits between the pipeline MEM stage and the DRAM instance.

Parameters:
- ADDR_BITS, 16, DRAM word-address width; byte address is ADDR_BITS+2 bits.
- RR_EN, 1, 1 = round-robin between m0/m1; 0 = fixed priority, m0 always wins.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- mX_req  in  1  request valid (X = 0, 1); held with attributes until mX_gnt.
- mX_we  in  1  1 = store, 0 = load.
- mX_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- mX_sext  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- mX_addr  in  ADDR_BITS+2  byte address.
- mX_wdata  in  32  store data, LSB-aligned.
- mX_gnt  out  1  combinational; request accepted this cycle.
- mX_rvalid  out  1  read or error response valid.
- mX_rdata  out  32  extended load data.
- mX_err  out  1  misaligned or illegal-size response, qualified by mX_rvalid.
- ram_addra  out  ADDR_BITS  word address to DRAM.
- ram_wea  out  4  byte-lane write enables.
- ram_dina  out  32  lane-shifted write data.
- ram_douta  in  32  DRAM read data, valid the cycle after the address edge.
- conflict_cnt  out  32  number of cycles in which both requesters were requesting.

Behaviour:
- Reset (synchronous, rst = 1 at an edge):
  - pending-read register cleared.
  - rr_last = 1, so m0 wins the first tie.
  - conflict_cnt = 0.
  - All mX_gnt/rvalid/err = 0, mX_rdata = 0, ram_wea = 0, ram_addra = 0, ram_dina = 0.
  - While rst is high, gnt is forced to 0.
- Arbitration (combinational, same cycle as req):
  - Only one requester → grant it.
  - Both requesting, RR_EN = 1 → grant the requester that is not rr_last.
  - Both requesting, RR_EN = 0 → grant m0.
  - rr_last updates to the winner on each grant.
  - conflict_cnt increments when m0_req & m1_req & !rst; it wraps at 2^32.
- Issue (grant cycle):
  - ram_addra = addr[ADDR_BITS+1:2].
  - Store:
    - byte: wea = 4'b0001 << off.
    - half: wea = 4'b0011 << off.
    - word: wea = 4'b1111.
    - ram_dina = wdata replicated across lanes (byte ×4, half ×2).
  - Load: wea = 0.
  - Misaligned (half with off[0] = 1, word with off ≠ 0) or size = 3: wea = 0 and no RAM write, but still granted.
  - No grant: wea = 0, addra = 0, dina = 0.
- Response pipeline (1 stage):
  - On a granted load or error, register {valid, id, off, size, sext, err}.
  - Next cycle, the owner sees rvalid = 1.
  - For a non-error load, rdata is taken from ram_douta:
    - byte: lane off.
    - half: bits [16·off[1]+15 : 16·off[1]].
    - word: all 32 bits.
    - Result is extended per sext.
  - For an error: err = 1, rdata = 0.
  - Stores produce no response.
  - Back-to-back grants every cycle are allowed; a response and a new grant may coexist in the same cycle.
  - Non-owner rvalid = 0 and rdata = 0.
- Simultaneous store (granted) and pending read to the same word in the next cycle: the read returns the pre-store contents.
  - Reason: the read was latched the cycle before; this is DRAM write-first on its own address only.
- Reset mid-read: the pending entry is dropped; no rvalid the cycle after rst.

Test Plan:
- Single-requester word path: m0 store word 0xDEADBEEF @0x0010 → wea = 1111, addra = 4. Then m0 load word @0x0010 → gnt same cycle; next cycle m0_rvalid = 1, rdata = 0xDEADBEEF, err = 0.
- Byte lanes and extension: m0 store byte 0x80 @0x0013 → wea = 1000, dina = 0x80808080. Load byte sext = 1 @0x0013 → rdata = 0xFFFFFF80. Load half sext = 0 @0x0012 → rdata = 0x000080xx, where xx = prior byte 2.
- Round-robin with RR_EN = 1: m0 and m1 both hold load requests for 4 cycles from reset → grants m0, m1, m0, m1; each rvalid goes to the correct port one cycle after its grant; conflict_cnt = 4.
- Fixed priority with RR_EN = 0: same stimulus → m0 granted all 4 cycles; m1_gnt = 0.
- Misaligned/illegal: m1 load word @0x0006 → gnt = 1, wea = 0; next cycle m1_rvalid = 1, err = 1, rdata = 0. m1 store size = 3 → no RAM write, err response next cycle.
- Reset mid-operation: m0 load granted in cycle N, rst = 1 in cycle N+1 → m0_rvalid = 0 in N+1 and N+2; conflict_cnt = 0; after release, m0 wins the first tie.

Source files
------------

// File: rtl/dram_port_arbiter_if.sv
// dram_port_arbiter_if
//   One requester's view of the shared data RAM. The requester drives the
//   request attributes and holds them until gnt; the arbiter returns the
//   grant and a single-cycle read/error response one cycle after the grant.
//
//   Signals (master = requester, slave = arbiter):
//     req    m->s  request valid, held with its attributes until gnt
//     we     m->s  1 = store, 0 = load
//     size   m->s  0 = byte, 1 = half, 2 = word, 3 = illegal
//     sext   m->s  loads: 1 = sign-extend, 0 = zero-extend
//     addr   m->s  byte address, ADDR_BITS+2 bits
//     wdata  m->s  store data, LSB-aligned
//     gnt    s->m  combinational accept, same cycle as req
//     rvalid s->m  read or error response valid
//     rdata  s->m  extended load data (0 on error)
//     err    s->m  misaligned / illegal size, qualified by rvalid
interface dram_port_arbiter_if #(
  parameter int ADDR_BITS = 16
);
  logic                 req;
  logic                 we;
  logic [1:0]           size;
  logic                 sext;
  logic [ADDR_BITS+1:0] addr;
  logic [31:0]          wdata;
  logic                 gnt;
  logic                 rvalid;
  logic [31:0]          rdata;
  logic                 err;

  modport master (
    output req, we, size, sext, addr, wdata,
    input  gnt, rvalid, rdata, err
  );

  modport slave (
    input  req, we, size, sext, addr, wdata,
    output gnt, rvalid, rdata, err
  );
endinterface

// File: rtl/dram_port_arbiter.sv
// dram_port_arbiter
//   Shares a single-port, 1-cycle-read-latency data RAM between two
//   requesters (m0 = CPU MEM stage, m1 = trace/debug/loader). Grants one
//   request per cycle, turns byte address + size into a word address and
//   lane write strobes, and returns aligned/extended read data (or an error
//   response) to the owning requester one cycle after the grant.
//
//   Ports:
//     clk            system clock, all state on the rising edge
//     rst            synchronous active-high reset
//     m0, m1         requester interfaces (slave side)
//     o_ram_addra    word address to the RAM
//     o_ram_wea      byte-lane write enables
//     o_ram_dina     lane-replicated write data
//     i_ram_douta    RAM read data, valid the cycle after the address edge
//     o_conflict_cnt cycles in which both requesters were requesting
module dram_port_arbiter #(
  parameter int ADDR_BITS = 16,
  parameter bit RR_EN     = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  dram_port_arbiter_if.slave    m0,
  dram_port_arbiter_if.slave    m1,
  output logic [ADDR_BITS-1:0]  o_ram_addra,
  output logic [3:0]            o_ram_wea,
  output logic [31:0]           o_ram_dina,
  input  logic [31:0]           i_ram_douta,
  output logic [31:0]           o_conflict_cnt
);
  localparam int BA = ADDR_BITS + 2;

  // Requester inputs gathered into index-able arrays (0 = m0, 1 = m1).
  logic [1:0]    w_req;
  logic [1:0]    w_we;
  logic [1:0]    w_sext;
  logic [1:0]    w_size  [2];
  logic [BA-1:0] w_addr  [2];
  logic [31:0]   w_wdata [2];

  assign w_req      = {m1.req, m0.req};
  assign w_we       = {m1.we, m0.we};
  assign w_sext     = {m1.sext, m0.sext};
  assign w_size[0]  = m0.size;
  assign w_size[1]  = m1.size;
  assign w_addr[0]  = m0.addr;
  assign w_addr[1]  = m1.addr;
  assign w_wdata[0] = m0.wdata;
  assign w_wdata[1] = m1.wdata;

  // State
  logic        r_rr_last;      // id of the most recent winner
  logic [31:0] r_conflict_cnt;
  logic        r_pend_valid;
  logic        r_pend_id;
  logic [1:0]  r_pend_off;
  logic [1:0]  r_pend_size;
  logic        r_pend_sext;
  logic        r_pend_err;

  // Arbitration: on a tie the requester that did not win last time gets it
  // (round-robin), or m0 always (fixed priority).
  logic [1:0] w_gnt;
  always_comb begin
    w_gnt = 2'b00;
    if (!rst) begin
      if (w_req[0] && w_req[1]) begin
        if (RR_EN && !r_rr_last) w_gnt = 2'b10;
        else                     w_gnt = 2'b01;
      end else begin
        w_gnt = w_req;
      end
    end
  end

  assign m0.gnt = w_gnt[0];
  assign m1.gnt = w_gnt[1];

  // Winner's attributes
  logic          w_any_gnt;
  logic          w_id;
  logic          w_sel_we;
  logic          w_sel_sext;
  logic [1:0]    w_sel_size;
  logic [BA-1:0] w_sel_addr;
  logic [31:0]   w_sel_wdata;
  logic [1:0]    w_off;
  logic          w_sel_err;

  assign w_any_gnt   = |w_gnt;
  assign w_id        = w_gnt[1];
  assign w_sel_we    = w_we[w_id];
  assign w_sel_sext  = w_sext[w_id];
  assign w_sel_size  = w_size[w_id];
  assign w_sel_addr  = w_addr[w_id];
  assign w_sel_wdata = w_wdata[w_id];
  assign w_off       = w_sel_addr[1:0];

  // Misaligned half/word, or the illegal size code.
  always_comb begin
    case (w_sel_size)
      2'd0:    w_sel_err = 1'b0;
      2'd1:    w_sel_err = w_off[0];
      2'd2:    w_sel_err = |w_off;
      default: w_sel_err = 1'b1;
    endcase
  end

  // Issue to the RAM in the grant cycle. Erroneous stores are still granted
  // (they get an error response) but never write.
  always_comb begin
    o_ram_addra = '0;
    o_ram_wea   = 4'b0000;
    o_ram_dina  = 32'h0;
    if (w_any_gnt) begin
      o_ram_addra = w_sel_addr[BA-1:2];
      if (w_sel_we) begin
        case (w_sel_size)
          2'd0:    o_ram_dina = {4{w_sel_wdata[7:0]}};
          2'd1:    o_ram_dina = {2{w_sel_wdata[15:0]}};
          default: o_ram_dina = w_sel_wdata;
        endcase
        if (!w_sel_err) begin
          case (w_sel_size)
            2'd0:    o_ram_wea = 4'b0001 << w_off;
            2'd1:    o_ram_wea = 4'b0011 << w_off;
            default: o_ram_wea = 4'b1111;
          endcase
        end
      end
    end
  end

  // Response tracking: loads and any error produce a response next cycle;
  // valid stores do not.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_valid   <= 1'b0;
      r_pend_id      <= 1'b0;
      r_pend_off     <= 2'd0;
      r_pend_size    <= 2'd0;
      r_pend_sext    <= 1'b0;
      r_pend_err     <= 1'b0;
      r_rr_last      <= 1'b1;
      r_conflict_cnt <= 32'h0;
    end else begin
      r_pend_valid <= w_any_gnt && (!w_sel_we || w_sel_err);
      if (w_any_gnt) begin
        r_pend_id   <= w_id;
        r_pend_off  <= w_off;
        r_pend_size <= w_sel_size;
        r_pend_sext <= w_sel_sext;
        r_pend_err  <= w_sel_err;
        r_rr_last   <= w_id;
      end
      if (w_req[0] && w_req[1]) begin
        r_conflict_cnt <= r_conflict_cnt + 32'd1;
      end
    end
  end

  assign o_conflict_cnt = r_conflict_cnt;

  // Lane extraction and extension of the RAM word for the pending load.
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_rsp_data;
  logic        w_rsp_valid;

  always_comb begin
    case (r_pend_off)
      2'd0:    w_byte = i_ram_douta[7:0];
      2'd1:    w_byte = i_ram_douta[15:8];
      2'd2:    w_byte = i_ram_douta[23:16];
      default: w_byte = i_ram_douta[31:24];
    endcase
  end

  assign w_half = r_pend_off[1] ? i_ram_douta[31:16] : i_ram_douta[15:0];

  always_comb begin
    w_rsp_data = 32'h0;
    if (!r_pend_err) begin
      case (r_pend_size)
        2'd0:    w_rsp_data = {{24{r_pend_sext & w_byte[7]}}, w_byte};
        2'd1:    w_rsp_data = {{16{r_pend_sext & w_half[15]}}, w_half};
        default: w_rsp_data = i_ram_douta;
      endcase
    end
  end

  // Responses are suppressed while rst is high so a read latched just
  // before reset never surfaces.
  assign w_rsp_valid = r_pend_valid && !rst;

  logic [1:0]  w_rvalid;
  logic [1:0]  w_err;
  logic [31:0] w_rdata [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
    assign w_rvalid[gi] = w_rsp_valid && (r_pend_id == 1'(gi));
    assign w_err[gi]    = w_rvalid[gi] && r_pend_err;
    assign w_rdata[gi]  = w_rvalid[gi] ? w_rsp_data : 32'h0;
  end

  assign m0.rvalid = w_rvalid[0];
  assign m0.err    = w_err[0];
  assign m0.rdata  = w_rdata[0];
  assign m1.rvalid = w_rvalid[1];
  assign m1.err    = w_err[1];
  assign m1.rdata  = w_rdata[1];
endmodule

// File: tb/tb_dram_port_arbiter.sv
module tb_dram_port_arbiter;
  localparam int AB     = 8;
  localparam int BA     = AB + 2;
  localparam int NBYTES = 4 << AB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Round-robin DUT and a fixed-priority twin fed the same requests.
  dram_port_arbiter_if #(.ADDR_BITS(AB)) m0 ();
  dram_port_arbiter_if #(.ADDR_BITS(AB)) m1 ();
  dram_port_arbiter_if #(.ADDR_BITS(AB)) f0 ();
  dram_port_arbiter_if #(.ADDR_BITS(AB)) f1 ();

  assign f0.req = m0.req;   assign f1.req = m1.req;
  assign f0.we = m0.we;     assign f1.we = m1.we;
  assign f0.size = m0.size; assign f1.size = m1.size;
  assign f0.sext = m0.sext; assign f1.sext = m1.sext;
  assign f0.addr = m0.addr; assign f1.addr = m1.addr;
  assign f0.wdata = m0.wdata; assign f1.wdata = m1.wdata;

  logic [AB-1:0] ram_addra;
  logic [3:0]    ram_wea;
  logic [31:0]   ram_dina;
  logic [31:0]   ram_douta = 32'h0;
  logic [31:0]   conflict_cnt;
  logic [AB-1:0] fp_addra;
  logic [3:0]    fp_wea;
  logic [31:0]   fp_dina;
  logic [31:0]   fp_conflict_cnt;
  logic [31:0]   fp_douta;
  assign fp_douta = 32'h0;

  dram_port_arbiter #(.ADDR_BITS(AB), .RR_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .m0(m0), .m1(m1),
    .o_ram_addra(ram_addra), .o_ram_wea(ram_wea), .o_ram_dina(ram_dina),
    .i_ram_douta(ram_douta), .o_conflict_cnt(conflict_cnt)
  );

  dram_port_arbiter #(.ADDR_BITS(AB), .RR_EN(1'b0)) u_fp (
    .clk(clk), .rst(rst), .m0(f0), .m1(f1),
    .o_ram_addra(fp_addra), .o_ram_wea(fp_wea), .o_ram_dina(fp_dina),
    .i_ram_douta(fp_douta), .o_conflict_cnt(fp_conflict_cnt)
  );

  // Data RAM: single port, byte-lane writes, registered write-first read.
  logic [31:0] ram_mem [0:(1<<AB)-1] = '{default: 32'h0};
  logic [31:0] ram_next;
  always_comb begin
    ram_next = ram_mem[ram_addra];
    for (int b = 0; b < 4; b++) if (ram_wea[b]) ram_next[8*b +: 8] = ram_dina[8*b +: 8];
  end
  always @(posedge clk) begin
    ram_mem[ram_addra] <= ram_next;
    ram_douta          <= ram_next;
  end

  // Reference model: byte-addressed memory and access rules.
  logic [7:0] mb [0:NBYTES-1];

  function automatic int nbytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic logic model_err(input logic [BA-1:0] addr, input logic [1:0] size);
    return (size == 2'd3) || ((int'(addr) % nbytes(size)) != 0);
  endfunction

  function automatic logic [3:0] model_wea(input logic we, input logic [BA-1:0] addr, input logic [1:0] size);
    if (!we || model_err(addr, size)) return 4'b0000;
    return 4'(((1 << nbytes(size)) - 1) << (int'(addr) % 4));
  endfunction

  function automatic logic [31:0] model_dina(input logic [31:0] wdata, input logic [1:0] size);
    logic [31:0] d;
    int nb;
    nb = nbytes(size);
    d = 32'h0;
    for (int i = 0; i < 4; i++) d[8*i +: 8] = wdata[8*(i % nb) +: 8];
    return d;
  endfunction

  function automatic logic [31:0] model_load(input logic [BA-1:0] addr, input logic [1:0] size, input logic sext);
    logic [31:0] v;
    int nb;
    nb = nbytes(size);
    v = 32'h0;
    for (int i = 0; i < nb; i++) v = v | (32'(mb[int'(addr) + i]) << (8*i));
    if (sext && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
    return v;
  endfunction

  task automatic model_store(input logic [BA-1:0] addr, input logic [1:0] size, input logic [31:0] wdata);
    for (int i = 0; i < nbytes(size); i++) mb[int'(addr) + i] = wdata[8*i +: 8];
  endtask

  function automatic logic port_rvalid(input int p);
    return (p == 0) ? m0.rvalid : m1.rvalid;
  endfunction
  function automatic logic port_err(input int p);
    return (p == 0) ? m0.err : m1.err;
  endfunction
  function automatic logic [31:0] port_rdata(input int p);
    return (p == 0) ? m0.rdata : m1.rdata;
  endfunction

  task automatic drive(input int p, input logic req, input logic we, input logic [1:0] size,
                       input logic sext, input logic [BA-1:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      m0.req = req; m0.we = we; m0.size = size; m0.sext = sext; m0.addr = addr; m0.wdata = wdata;
    end else begin
      m1.req = req; m1.we = we; m1.size = size; m1.sext = sext; m1.addr = addr; m1.wdata = wdata;
    end
  endtask

  task automatic idle();
    drive(0, 1'b0, 1'b0, 2'd0, 1'b0, '0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'd0, 1'b0, '0, 32'h0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive(0, 1'b1, 1'b1, 2'd2, 1'b0, BA'(16), 32'h1111_2222);
    drive(1, 1'b1, 1'b0, 2'd2, 1'b0, BA'(32), 32'h0);
    tick();
    @(negedge clk);
    $display("reset: both requesting under rst");
    checks++; if (m0.gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt0: got %b want 0", m0.gnt); end
    checks++; if (m1.gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt1: got %b want 0", m1.gnt); end
    checks++; if (ram_wea !== 4'h0) begin errors++; $display("FAIL rst_wea: got %h want 0", ram_wea); end
    checks++; if (ram_addra !== '0) begin errors++; $display("FAIL rst_addra: got %h want 0", ram_addra); end
    checks++; if (ram_dina !== 32'h0) begin errors++; $display("FAIL rst_dina: got %h want 0", ram_dina); end
    checks++; if (m0.rvalid !== 1'b0 || m1.rvalid !== 1'b0) begin errors++; $display("FAIL rst_rvalid: got %b%b want 00", m1.rvalid, m0.rvalid); end
    checks++; if (m0.rdata !== 32'h0 || m1.rdata !== 32'h0) begin errors++; $display("FAIL rst_rdata: got %h/%h want 0", m0.rdata, m1.rdata); end
    tick();
    @(negedge clk);
    checks++; if (conflict_cnt !== 32'h0) begin errors++; $display("FAIL rst_cnt: got %0d want 0", conflict_cnt); end
    tick();
    rst = 1'b0;
    idle();
  endtask

  task automatic test_word_path();
    drive(0, 1'b1, 1'b1, 2'd2, 1'b0, BA'(16), 32'hDEAD_BEEF);
    @(negedge clk);
    $display("m0 store word 0xdeadbeef @0x10");
    checks++; if (m0.gnt !== 1'b1 || m1.gnt !== 1'b0) begin errors++; $display("FAIL ws_gnt: got %b%b want 01", m1.gnt, m0.gnt); end
    checks++; if (ram_wea !== 4'b1111) begin errors++; $display("FAIL ws_wea: got %b want 1111", ram_wea); end
    checks++; if (ram_addra !== AB'(4)) begin errors++; $display("FAIL ws_addra: got %h want 4", ram_addra); end
    checks++; if (ram_dina !== 32'hDEAD_BEEF) begin errors++; $display("FAIL ws_dina: got %h want deadbeef", ram_dina); end
    model_store(BA'(16), 2'd2, 32'hDEAD_BEEF);
    tick();
    drive(0, 1'b1, 1'b0, 2'd2, 1'b0, BA'(16), 32'h0);
    @(negedge clk);
    $display("m0 load word @0x10");
    checks++; if (m0.gnt !== 1'b1) begin errors++; $display("FAIL wl_gnt: got %b want 1", m0.gnt); end
    checks++; if (ram_wea !== 4'b0000) begin errors++; $display("FAIL wl_wea: got %b want 0000", ram_wea); end
    checks++; if (m0.rvalid !== 1'b0) begin errors++; $display("FAIL ws_norsp: got %b want 0", m0.rvalid); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (m0.rvalid !== 1'b1) begin errors++; $display("FAIL wl_rvalid: got %b want 1", m0.rvalid); end
    checks++; if (m0.rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL wl_rdata: got %h want deadbeef", m0.rdata); end
    checks++; if (m0.err !== 1'b0) begin errors++; $display("FAIL wl_err: got %b want 0", m0.err); end
    checks++; if (m1.rvalid !== 1'b0 || m1.rdata !== 32'h0) begin errors++; $display("FAIL wl_nonowner: got %b %h want 0 0", m1.rvalid, m1.rdata); end
    tick();
  endtask

  task automatic test_byte_ext();
    drive(0, 1'b1, 1'b1, 2'd0, 1'b0, BA'(19), 32'h1234_5680);
    @(negedge clk);
    $display("m0 store byte 0x80 @0x13");
    checks++; if (ram_wea !== 4'b1000) begin errors++; $display("FAIL bs_wea: got %b want 1000", ram_wea); end
    checks++; if (ram_dina !== 32'h8080_8080) begin errors++; $display("FAIL bs_dina: got %h want 80808080", ram_dina); end
    model_store(BA'(19), 2'd0, 32'h1234_5680);
    tick();
    drive(0, 1'b1, 1'b0, 2'd0, 1'b1, BA'(19), 32'h0);
    @(negedge clk);
    $display("m0 load byte sext @0x13");
    checks++; if (m0.gnt !== 1'b1) begin errors++; $display("FAIL bl_gnt: got %b want 1", m0.gnt); end
    tick();
    drive(0, 1'b1, 1'b0, 2'd1, 1'b0, BA'(18), 32'h0);
    @(negedge clk);
    $display("m0 load half zext @0x12 (back-to-back)");
    checks++; if (m0.gnt !== 1'b1 || m0.rvalid !== 1'b1) begin errors++; $display("FAIL b2b_gnt_rv: got %b%b want 11", m0.gnt, m0.rvalid); end
    checks++; if (m0.rdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL bl_rdata: got %h want ffffff80", m0.rdata); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (m0.rvalid !== 1'b1 || m0.rdata !== 32'h0000_80AD) begin errors++; $display("FAIL hl_rdata: got %b %h want 1 000080ad", m0.rvalid, m0.rdata); end
    tick();
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 2'd2, 1'b0, BA'(16), 32'h0);
    drive(1, 1'b1, 1'b0, 2'd1, 1'b1, BA'(18), 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      $display("tie cycle %0d: rr gnt=%b%b fp gnt=%b%b", k, m1.gnt, m0.gnt, f1.gnt, f0.gnt);
      checks++; if (m0.gnt !== (k % 2 == 0) || m1.gnt !== (k % 2 == 1)) begin errors++; $display("FAIL rr_gnt%0d: got %b%b want %b%b", k, m1.gnt, m0.gnt, k % 2 == 1, k % 2 == 0); end
      checks++; if (f0.gnt !== 1'b1 || f1.gnt !== 1'b0) begin errors++; $display("FAIL fp_gnt%0d: got %b%b want 01", k, f1.gnt, f0.gnt); end
      if (k > 0) begin
        if (k % 2 == 1) begin
          checks++; if (m0.rvalid !== 1'b1 || m1.rvalid !== 1'b0 || m0.rdata !== 32'h80AD_BEEF) begin errors++; $display("FAIL rr_rsp%0d: got rv=%b%b d=%h want 01 80adbeef", k, m1.rvalid, m0.rvalid, m0.rdata); end
        end else begin
          checks++; if (m1.rvalid !== 1'b1 || m0.rvalid !== 1'b0 || m1.rdata !== 32'hFFFF_80AD) begin errors++; $display("FAIL rr_rsp%0d: got rv=%b%b d=%h want 10 ffff80ad", k, m1.rvalid, m0.rvalid, m1.rdata); end
        end
      end
      tick();
    end
    idle();
    @(negedge clk);
    checks++; if (m1.rvalid !== 1'b1 || m1.rdata !== 32'hFFFF_80AD) begin errors++; $display("FAIL rr_rsp_last: got %b %h want 1 ffff80ad", m1.rvalid, m1.rdata); end
    checks++; if (conflict_cnt !== 32'd4) begin errors++; $display("FAIL rr_cnt: got %0d want 4", conflict_cnt); end
    tick();
  endtask

  task automatic test_misaligned();
    drive(1, 1'b1, 1'b0, 2'd2, 1'b0, BA'(6), 32'h0);
    @(negedge clk);
    $display("m1 load word @0x006 (misaligned)");
    checks++; if (m1.gnt !== 1'b1 || ram_wea !== 4'b0) begin errors++; $display("FAIL mis_gnt_wea: got %b %b want 1 0000", m1.gnt, ram_wea); end
    tick();
    drive(1, 1'b1, 1'b1, 2'd3, 1'b0, BA'(32), 32'hCAFE_F00D);
    @(negedge clk);
    $display("m1 store size=3 @0x020");
    checks++; if (m1.gnt !== 1'b1 || ram_wea !== 4'b0) begin errors++; $display("FAIL ill_gnt_wea: got %b %b want 1 0000", m1.gnt, ram_wea); end
    checks++; if (m1.rvalid !== 1'b1 || m1.err !== 1'b1 || m1.rdata !== 32'h0) begin errors++; $display("FAIL mis_rsp: got %b %b %h want 1 1 0", m1.rvalid, m1.err, m1.rdata); end
    tick();
    drive(1, 1'b0, 1'b0, 2'd0, 1'b0, '0, 32'h0);
    drive(0, 1'b1, 1'b1, 2'd1, 1'b0, BA'(33), 32'h0000_5555);
    @(negedge clk);
    $display("m0 store half @0x021 (misaligned)");
    checks++; if (m1.rvalid !== 1'b1 || m1.err !== 1'b1 || m1.rdata !== 32'h0) begin errors++; $display("FAIL ill_rsp: got %b %b %h want 1 1 0", m1.rvalid, m1.err, m1.rdata); end
    checks++; if (m0.gnt !== 1'b1 || ram_wea !== 4'b0) begin errors++; $display("FAIL mish_wea: got %b %b want 1 0000", m0.gnt, ram_wea); end
    tick();
    idle();
    @(negedge clk);
    checks++; if (m0.rvalid !== 1'b1 || m0.err !== 1'b1) begin errors++; $display("FAIL mish_rsp: got %b %b want 1 1", m0.rvalid, m0.err); end
    tick();
  endtask

  task automatic test_reset_mid();
    drive(0, 1'b1, 1'b0, 2'd2, 1'b0, BA'(16), 32'h0);
    @(negedge clk);
    $display("m0 load @0x10 then reset");
    checks++; if (m0.gnt !== 1'b1) begin errors++; $display("FAIL rm_gnt: got %b want 1", m0.gnt); end
    tick();
    rst = 1'b1;
    idle();
    @(negedge clk);
    checks++; if (m0.rvalid !== 1'b0) begin errors++; $display("FAIL rm_rv1: got %b want 0", m0.rvalid); end
    tick();
    rst = 1'b0;
    drive(0, 1'b1, 1'b0, 2'd2, 1'b0, BA'(16), 32'h0);
    drive(1, 1'b1, 1'b0, 2'd2, 1'b0, BA'(20), 32'h0);
    @(negedge clk);
    checks++; if (m0.rvalid !== 1'b0) begin errors++; $display("FAIL rm_rv2: got %b want 0", m0.rvalid); end
    checks++; if (conflict_cnt !== 32'h0) begin errors++; $display("FAIL rm_cnt: got %0d want 0", conflict_cnt); end
    checks++; if (m0.gnt !== 1'b1 || m1.gnt !== 1'b0) begin errors++; $display("FAIL rm_tie: got %b%b want 01", m1.gnt, m0.gnt); end
    tick();
    idle();
    tick();
  endtask

  task automatic test_random();
    logic          act   [2];
    logic          a_we  [2];
    logic [1:0]    a_sz  [2];
    logic          a_sx  [2];
    logic [BA-1:0] a_ad  [2];
    logic [31:0]   a_wd  [2];
    int            last_win;
    int            win;
    logic [31:0]   cnt_m;
    logic          both;
    logic          pend_v;
    int            pend_id;
    logic          pend_err;
    logic [31:0]   pend_data;
    logic          e;
    rst = 1'b1;
    idle();
    tick();
    rst = 1'b0;
    last_win = 1;
    cnt_m = 32'h0;
    pend_v = 1'b0;
    pend_id = 0;
    pend_err = 1'b0;
    pend_data = 32'h0;
    for (int p = 0; p < 2; p++) act[p] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p] && $urandom_range(0, 99) < 60) begin
          act[p]  = 1'b1;
          a_we[p] = 1'($urandom_range(0, 1));
          a_sz[p] = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
          a_sx[p] = 1'($urandom_range(0, 1));
          a_ad[p] = BA'($urandom_range(0, 63));
          if (a_sz[p] != 2'd3 && $urandom_range(0, 3) != 0) a_ad[p] = a_ad[p] & ~BA'(nbytes(a_sz[p]) - 1);
          a_wd[p] = $urandom;
        end
        if (act[p]) drive(p, 1'b1, a_we[p], a_sz[p], a_sx[p], a_ad[p], a_wd[p]);
        else drive(p, 1'b0, 1'b0, 2'd0, 1'b0, '0, 32'h0);
      end
      @(negedge clk);
      both = act[0] && act[1];
      if (both) win = 1 - last_win;
      else if (act[0]) win = 0;
      else if (act[1]) win = 1;
      else win = -1;
      checks++; if (m0.gnt !== (win == 0) || m1.gnt !== (win == 1)) begin errors++; $display("FAIL rnd_gnt c%0d: got %b%b want winner %0d", c, m1.gnt, m0.gnt, win); end
      checks++; if (conflict_cnt !== cnt_m) begin errors++; $display("FAIL rnd_cnt c%0d: got %0d want %0d", c, conflict_cnt, cnt_m); end
      for (int p = 0; p < 2; p++) begin
        checks++;
        if (pend_v && pend_id == p) begin
          if (port_rvalid(p) !== 1'b1 || port_err(p) !== pend_err || port_rdata(p) !== pend_data) begin
            errors++; $display("FAIL rnd_rsp c%0d m%0d: got rv=%b err=%b d=%h want 1 %b %h", c, p, port_rvalid(p), port_err(p), port_rdata(p), pend_err, pend_data);
          end
        end else if (port_rvalid(p) !== 1'b0 || port_rdata(p) !== 32'h0) begin
          errors++; $display("FAIL rnd_idle c%0d m%0d: got rv=%b d=%h want 0 0", c, p, port_rvalid(p), port_rdata(p));
        end
      end
      pend_v = 1'b0;
      if (win >= 0) begin
        e = model_err(a_ad[win], a_sz[win]);
        $display("c%0d m%0d %s size=%0d addr=%h err=%b", c, win, a_we[win] ? "store" : "load", a_sz[win], a_ad[win], e);
        checks++; if (ram_addra !== a_ad[win][BA-1:2]) begin errors++; $display("FAIL rnd_addra c%0d: got %h want %h", c, ram_addra, a_ad[win][BA-1:2]); end
        checks++; if (ram_wea !== model_wea(a_we[win], a_ad[win], a_sz[win])) begin errors++; $display("FAIL rnd_wea c%0d: got %b want %b", c, ram_wea, model_wea(a_we[win], a_ad[win], a_sz[win])); end
        if (a_we[win] && !e) begin
          checks++; if (ram_dina !== model_dina(a_wd[win], a_sz[win])) begin errors++; $display("FAIL rnd_dina c%0d: got %h want %h", c, ram_dina, model_dina(a_wd[win], a_sz[win])); end
          model_store(a_ad[win], a_sz[win], a_wd[win]);
        end else begin
          pend_v    = 1'b1;
          pend_id   = win;
          pend_err  = e;
          pend_data = e ? 32'h0 : model_load(a_ad[win], a_sz[win], a_sx[win]);
        end
        last_win = win;
        act[win] = 1'b0;
      end
      if (both) cnt_m = cnt_m + 32'd1;
      tick();
    end
  endtask

  initial begin
    for (int i = 0; i < NBYTES; i++) mb[i] = 8'h00;
    idle();
    test_reset();
    test_word_path();
    test_byte_ext();
    test_round_robin();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
